// File: rtl/paddle_pkg.sv
// Shared types and default playfield constants for the paddle tracker.
//   state_e : motion FSM states
//   dir_e   : decoded button direction
//   FIELD_MAX_DEF / HALF_LEN_DEF : default playfield extent and paddle half-length
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_UP = 2'd1,
    RUN_DN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  localparam int FIELD_MAX_DEF = 480;
  localparam int HALF_LEN_DEF  = 32;

endpackage

// File: rtl/paddle_rate_gen.sv
// Step-rate generator: tick counter, acceleration level and hold counter.
//   clk            : system clock
//   i_rst_n        : asynchronous active-low reset
//   i_run          : count ticks this cycle (steady motion in one direction)
//   i_clear        : restart counting at level 0 (direction change, recentre)
//   i_ticks_per_px : base clocks per 1-px step
//   o_step         : strobe, high in the cycle a step is taken
module paddle_rate_gen #(
  parameter int TICK_W       = 16,
  parameter int ACCEL_LEVELS = 4,
  parameter int ACCEL_HOLD   = 8
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic              i_clear,
  input  logic [TICK_W-1:0] i_ticks_per_px,
  output logic              o_step
);

  localparam int LVL_W  = (ACCEL_LEVELS > 1) ? $clog2(ACCEL_LEVELS) : 1;
  localparam int HOLD_W = (ACCEL_HOLD > 1) ? $clog2(ACCEL_HOLD) : 1;
  localparam logic [LVL_W-1:0]  LVL_TOP  = LVL_W'(ACCEL_LEVELS - 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(ACCEL_HOLD - 1);

  logic [TICK_W-1:0] r_tick;
  logic [LVL_W-1:0]  r_level;
  logic [HOLD_W-1:0] r_hold;

  logic [TICK_W-1:0] w_shifted;
  logic [TICK_W-1:0] w_period;
  logic              w_step;

  // Each level halves the period; a zero period (ticks_per_px=0 or shifted
  // out) still means one step per clock.
  assign w_shifted = i_ticks_per_px >> r_level;
  assign w_period  = (w_shifted == '0) ? TICK_W'(1) : w_shifted;
  // ">=" so that shrinking ticks_per_px mid-period steps at once.
  assign w_step    = i_run & ~i_clear & (r_tick >= (w_period - TICK_W'(1)));
  assign o_step    = w_step;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick  <= '0;
      r_level <= '0;
      r_hold  <= '0;
    end else if (i_clear) begin
      r_tick  <= '0;
      r_level <= '0;
      r_hold  <= '0;
    end else if (w_step) begin
      r_tick <= '0;
      if (r_hold == HOLD_TOP) begin
        r_hold <= '0;
        if (r_level != LVL_TOP) r_level <= r_level + LVL_W'(1);
      end else begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end else if (i_run) begin
      r_tick <= r_tick + TICK_W'(1);
    end
  end

endmodule

// File: rtl/paddle_motion.sv
// Paddle centre tracker: turns up/down button levels into a paddle centre
// position with tick-based stepping, acceleration, clamp/wrap edges,
// recentre and a limit-hit flag.
//   clk, reset (async active-low)
//   up/down      : move requests (+/- position); game_on gates motion
//   wrap_mode    : 1 = wrap at field edges, 0 = clamp to paddle-safe range
//   recentre     : one-cycle request to return to FIELD_MAX/2
//   ticks_per_px : base clocks per 1-px step
//   position     : registered paddle centre
//   moving_up/moving_down : pulse in the cycle after a step
//   at_limit     : clamp mode, centre at a bound with the request pushing into it
module paddle_motion
  import paddle_pkg::*;
#(
  parameter int FIELD_MAX    = FIELD_MAX_DEF,
  parameter int POS_W        = 10,
  parameter int TICK_W       = 16,
  parameter int HALF_LEN     = HALF_LEN_DEF,
  parameter int ACCEL_LEVELS = 4,
  parameter int ACCEL_HOLD   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up,
  input  logic              down,
  input  logic              game_on,
  input  logic              wrap_mode,
  input  logic              recentre,
  input  logic [TICK_W-1:0] ticks_per_px,
  output logic [POS_W-1:0]  position,
  output logic              moving_up,
  output logic              moving_down,
  output logic              at_limit
);

  localparam logic [POS_W-1:0] C_MID = POS_W'(FIELD_MAX / 2);
  localparam logic [POS_W-1:0] C_MAX = POS_W'(FIELD_MAX);
  localparam logic [POS_W-1:0] C_LO  = POS_W'(HALF_LEN);
  localparam logic [POS_W-1:0] C_HI  = POS_W'(FIELD_MAX - HALF_LEN);

  state_e           r_state;
  logic [POS_W-1:0] r_pos;
  logic             r_mv_up;
  logic             r_mv_dn;
  logic             r_at_limit;

  dir_e   w_dir;
  state_e w_tgt;
  logic   w_trans;
  logic   w_run;
  logic   w_clear;
  logic   w_step;

  always_comb begin
    w_dir = DIR_NONE;
    if (game_on) begin
      if (up && !down)      w_dir = DIR_UP;
      else if (down && !up) w_dir = DIR_DN;
    end
  end

  always_comb begin
    w_tgt = IDLE;
    case (w_dir)
      DIR_UP:  w_tgt = RUN_UP;
      DIR_DN:  w_tgt = RUN_DN;
      default: w_tgt = IDLE;
    endcase
  end

  // Any state change (start, stop, reversal) restarts the rate generator
  // at level 0 and takes no step in that cycle.
  assign w_trans = (w_tgt != r_state);
  assign w_run   = (r_state != IDLE) && !w_trans;
  assign w_clear = w_trans || recentre;

  paddle_rate_gen #(
    .TICK_W       (TICK_W),
    .ACCEL_LEVELS (ACCEL_LEVELS),
    .ACCEL_HOLD   (ACCEL_HOLD)
  ) u_rate (
    .clk            (clk),
    .i_rst_n        (reset),
    .i_run          (w_run),
    .i_clear        (w_clear),
    .i_ticks_per_px (ticks_per_px),
    .o_step         (w_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pos      <= C_MID;
      r_mv_up    <= 1'b0;
      r_mv_dn    <= 1'b0;
      r_at_limit <= 1'b0;
    end else begin
      // Recentre holds the FSM where it is; it only resets the rate.
      if (!recentre) r_state <= w_tgt;

      r_mv_up    <= 1'b0;
      r_mv_dn    <= 1'b0;
      r_at_limit <= !wrap_mode && !recentre &&
                    (((w_dir == DIR_UP) && (r_pos >= C_HI)) ||
                     ((w_dir == DIR_DN) && (r_pos <= C_LO)));

      if (recentre) begin
        r_pos <= C_MID;
      end else if (!wrap_mode && (r_pos > C_HI)) begin
        // Left over from wrap mode: snap into the clamp range silently.
        r_pos <= C_HI;
      end else if (!wrap_mode && (r_pos < C_LO)) begin
        r_pos <= C_LO;
      end else if (w_step && (r_state == RUN_UP)) begin
        if (wrap_mode) begin
          r_pos   <= (r_pos >= C_MAX) ? '0 : r_pos + POS_W'(1);
          r_mv_up <= 1'b1;
        end else if (r_pos < C_HI) begin
          r_pos   <= r_pos + POS_W'(1);
          r_mv_up <= 1'b1;
        end
      end else if (w_step && (r_state == RUN_DN)) begin
        if (wrap_mode) begin
          r_pos   <= (r_pos == '0) ? C_MAX : r_pos - POS_W'(1);
          r_mv_dn <= 1'b1;
        end else if (r_pos > C_LO) begin
          r_pos   <= r_pos - POS_W'(1);
          r_mv_dn <= 1'b1;
        end
      end
    end
  end

  assign position    = r_pos;
  assign moving_up   = r_mv_up;
  assign moving_down = r_mv_dn;
  assign at_limit    = r_at_limit;

endmodule

// File: tb/tb_paddle_motion.sv
module tb_paddle_motion;

  logic        clk = 1'b0;
  logic        reset;
  logic        up, down, game_on, wrap_mode, recentre;
  logic [15:0] ticks_per_px;

  logic [9:0]  pos_a, pos_b;
  logic        mu_a, md_a, al_a;
  logic        mu_b, md_b, al_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  paddle_motion dut (
    .clk          (clk),
    .reset        (reset),
    .up           (up),
    .down         (down),
    .game_on      (game_on),
    .wrap_mode    (wrap_mode),
    .recentre     (recentre),
    .ticks_per_px (ticks_per_px),
    .position     (pos_a),
    .moving_up    (mu_a),
    .moving_down  (md_a),
    .at_limit     (al_a)
  );

  paddle_motion #(.ACCEL_HOLD(2)) dut_acc (
    .clk          (clk),
    .reset        (reset),
    .up           (up),
    .down         (down),
    .game_on      (game_on),
    .wrap_mode    (wrap_mode),
    .recentre     (recentre),
    .ticks_per_px (ticks_per_px),
    .position     (pos_b),
    .moving_up    (mu_b),
    .moving_down  (md_b),
    .at_limit     (al_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    up           = 1'b0;
    down         = 1'b0;
    game_on      = 1'b1;
    wrap_mode    = 1'b0;
    recentre     = 1'b0;
    ticks_per_px = 16'd1;
    cyc(2);
    reset = 1'b1;
  endtask

  // Edges at which the ACCEL_HOLD=2 instance steps, counted from the edge
  // that enters RUN_UP with ticks_per_px=8: intervals 8,8,4,4,2,2,1,1,...
  int acc_steps[12] = '{9, 17, 21, 25, 27, 29, 30, 31, 32, 33, 34, 35};

  initial begin
    do_reset();
    chk("rst_pos", int'(pos_a), 240);
    chk("rst_mu", int'(mu_a), 0);
    chk("rst_md", int'(md_a), 0);
    chk("rst_al", int'(al_a), 0);

    // Reset asserted mid-run acts without a clock edge
    ticks_per_px = 16'd4;
    up = 1'b1;
    cyc(100);
    chk("run_moved", int'(pos_a != 10'd240), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_pos", int'(pos_a), 240);
    chk("async_mu", int'(mu_a), 0);
    chk("async_al", int'(al_a), 0);

    // Base rate: period 4
    do_reset();
    ticks_per_px = 16'd4;
    up = 1'b1;
    cyc(1);
    chk("base_e1", int'(pos_a), 240);
    cyc(3);
    chk("base_e4", int'(pos_a), 240);
    chk("base_e4_mu", int'(mu_a), 0);
    cyc(1);
    chk("base_e5", int'(pos_a), 241);
    chk("base_e5_mu", int'(mu_a), 1);
    cyc(1);
    chk("base_e6_mu", int'(mu_a), 0);
    cyc(3);
    chk("base_e9", int'(pos_a), 242);
    chk("base_e9_mu", int'(mu_a), 1);
    cyc(12);
    chk("base_e21", int'(pos_a), 245);

    // Acceleration on the ACCEL_HOLD=2 instance
    do_reset();
    ticks_per_px = 16'd8;
    up = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      int n_st;
      int is_st;
      cyc(1);
      n_st  = 0;
      is_st = 0;
      for (int k = 0; k < 12; k++) begin
        if (acc_steps[k] <= e) n_st++;
        if (acc_steps[k] == e) is_st = 1;
      end
      chk($sformatf("acc_pos_e%0d", e), int'(pos_b), 240 + n_st);
      chk($sformatf("acc_mu_e%0d", e), int'(mu_b), is_st);
    end

    // Clamp at FIELD_MAX-HALF_LEN = 448
    do_reset();
    ticks_per_px = 16'd1;
    up = 1'b1;
    cyc(208);
    chk("clamp_447", int'(pos_a), 447);
    cyc(1);
    chk("clamp_448", int'(pos_a), 448);
    chk("clamp_448_mu", int'(mu_a), 1);
    chk("clamp_448_al", int'(al_a), 0);
    cyc(1);
    chk("clamp_hold", int'(pos_a), 448);
    chk("clamp_hold_mu", int'(mu_a), 0);
    chk("clamp_hold_al", int'(al_a), 1);
    cyc(5);
    chk("clamp_late", int'(pos_a), 448);
    chk("clamp_late_mu", int'(mu_a), 0);
    chk("clamp_late_al", int'(al_a), 1);
    up = 1'b0;
    cyc(1);
    chk("clamp_rel_al", int'(al_a), 0);

    // Wrap both ways, then switch to clamp
    do_reset();
    wrap_mode = 1'b1;
    ticks_per_px = 16'd1;
    up = 1'b1;
    cyc(241);
    chk("wrap_480", int'(pos_a), 480);
    cyc(1);
    chk("wrap_up_0", int'(pos_a), 0);
    chk("wrap_up_mu", int'(mu_a), 1);
    chk("wrap_up_al", int'(al_a), 0);
    up = 1'b0;
    down = 1'b1;
    cyc(1);
    chk("wrap_rev_pos", int'(pos_a), 0);
    chk("wrap_rev_md", int'(md_a), 0);
    cyc(1);
    chk("wrap_dn_480", int'(pos_a), 480);
    chk("wrap_dn_md", int'(md_a), 1);
    chk("wrap_dn_al", int'(al_a), 0);
    down = 1'b0;
    wrap_mode = 1'b0;
    cyc(1);
    chk("mode_sw_pos", int'(pos_a), 448);
    chk("mode_sw_md", int'(md_a), 0);
    chk("mode_sw_mu", int'(mu_a), 0);

    // Both buttons, and game_on low
    do_reset();
    up = 1'b1;
    down = 1'b1;
    cyc(10);
    chk("both_pos", int'(pos_a), 240);
    chk("both_mu", int'(mu_a), 0);
    chk("both_md", int'(md_a), 0);
    down = 1'b0;
    game_on = 1'b0;
    cyc(10);
    chk("gameoff_pos", int'(pos_a), 240);

    // Reversal after acceleration restarts at level 0
    do_reset();
    ticks_per_px = 16'd8;
    up = 1'b1;
    cyc(18);
    chk("rev_pre", int'(pos_b), 242);
    up = 1'b0;
    down = 1'b1;
    cyc(1);
    chk("rev_cycle", int'(pos_b), 242);
    cyc(7);
    chk("rev_e26", int'(pos_b), 242);
    chk("rev_e26_md", int'(md_b), 0);
    cyc(1);
    chk("rev_e27", int'(pos_b), 241);
    chk("rev_e27_md", int'(md_b), 1);

    // Recentre coinciding with a step
    do_reset();
    ticks_per_px = 16'd4;
    up = 1'b1;
    cyc(4);
    recentre = 1'b1;
    cyc(1);
    chk("rc_pos", int'(pos_a), 240);
    chk("rc_mu", int'(mu_a), 0);
    recentre = 1'b0;
    cyc(3);
    chk("rc_e8", int'(pos_a), 240);
    cyc(1);
    chk("rc_e9", int'(pos_a), 241);
    chk("rc_e9_mu", int'(mu_a), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
